fpga_config_loader: RTL and testbench
=====================================

// Module: fpga_config_loader
// PURPOSE
// - Loads the fabric configuration from a byte-wide bitstream into one flat config vector.
// - The vector is sliced at top level into brbselect, leftioselect, rightioselect,
//   topioselect and bottomioselect, which drive the routing and io_block instances.
// - Sits directly upstream of the routing and IO select ports.
// - Validates each frame with a checksum and commits atomically, so the fabric never
//   sees a partial configuration.
// PARAMETERS
// - CFG_BITS  1020  config vector width (900 routing + 4 x 30 IO select)
// - NBYTES    (CFG_BITS+7)/8 = 128  payload bytes per frame (localparam, derived)
// - CNT_W     $clog2(NBYTES+1)      byte counter width (localparam, derived)
// PORTS
// - clk        in   1         single clock, rising edge
// - rst_n      in   1         asynchronous active-low reset
// - in_data    in   8         bitstream byte
// - in_valid   in   1         in_data valid
// - in_ready   out  1         loader accepts byte; transfer = in_valid & in_ready
// - cfg_out    out  CFG_BITS  committed configuration vector to the fabric
// - cfg_valid  out  1         cfg_out holds a checksum-verified frame
// - cfg_done   out  1         1-cycle pulse on commit
// - cfg_err    out  1         sticky: last frame failed checksum
// - busy       out  1         frame in progress (LOAD or CHK)
// BEHAVIOUR
// - Reset (async, any state, including mid-load):
//   - state=IDLE; cfg_out, shadow, counter, checksum all 0.
//   - cfg_valid=0, cfg_done=0, cfg_err=0, busy=0, in_ready=0 while rst_n=0.
// - Frame format: SYNC (8'hA5), NBYTES payload bytes, 1 checksum byte.
//   - Payload byte i carries config bits [8i+7:8i], LSB = lowest bit.
//   - Bits >= CFG_BITS in the last byte are ignored.
//   - Checksum = XOR of all payload bytes.
// - FSM states: IDLE, LOAD, CHK, COMMIT, ERR.
//   - IDLE: in_ready=1. Bytes other than A5 are discarded.
//     On A5: go to LOAD; cnt=0; xor=0; clear cfg_err.
//   - LOAD: in_ready=1. Each transfer writes shadow byte[cnt], xor ^= byte, cnt++.
//     After byte NBYTES-1: go to CHK. A5 inside the payload is data, not resync.
//   - CHK: in_ready=1. On transfer: byte==xor -> COMMIT, else -> ERR.
//   - COMMIT: in_ready=0, one cycle. cfg_out<=shadow; cfg_valid<=1; cfg_done=1.
//     Then IDLE.
//   - ERR: in_ready=0, one cycle. cfg_err<=1; cfg_out and cfg_valid unchanged.
//     Then IDLE.
// - Timing:
//   - Checksum byte accepted at edge t -> state COMMIT during cycle t..t+1.
//   - cfg_out, cfg_valid and cfg_done become visible after edge t+1.
//   - cfg_done is a registered pulse of exactly one cycle.
// - Stalls: in_valid=0 in any state holds state, cnt and xor. No timeout.
// - cfg_out changes only at COMMIT. No bit toggles during LOAD.
// - Reload: a new frame after a commit overwrites the shadow only.
//   - cfg_valid stays 1 through the new load.
//   - A failed reload keeps the old cfg_out with cfg_valid=1 and cfg_err=1.
// - busy = (state==LOAD) | (state==CHK).
// - Counter: cnt never exceeds NBYTES-1 in LOAD. No wrap-around is possible.
// STRUCTURE
// - Shared header fpga_cfg_defs.vh holds:
//   - SYNC_BYTE (8'hA5) and the FSM state encodings.
//   - Routing/IO slice offsets into cfg_out, also used by the fabric top and benches.
// - Sub-module cfg_shadow_reg (CFG_BITS wide): byte-addressed write port plus
//   parallel read. Keeps the loader FSM small.
// TESTING
// - Reset: assert rst_n=0 mid-LOAD after 10 bytes.
//   -> cfg_out=0, cfg_valid=0, busy=0 immediately.
//   -> After release, the next A5 starts a fresh frame.
// - Good frame: A5, byte0=8'h20, bytes1..127=0, chk=8'h20.
//   -> cfg_out[5]=1, all other bits 0.
//   -> cfg_done high for one cycle, 1 cycle after chk accepted; cfg_valid=1.
// - Bad checksum: commit the frame above, then send A5, byte0=8'h01, rest 0, chk=8'h00.
//   -> cfg_err=1; cfg_out[5]=1 and cfg_out[0]=0 retained; cfg_done stays 0.
// - Preamble garbage: send 8'h00, 8'hFF, 8'h5A before A5, then a valid frame.
//   -> Garbage ignored; commit is identical to the good-frame case.
// - Stalls and padding: randomly drop in_valid (~30%).
//   -> Result equals the no-stall run.
//   -> Last-byte bits 1020..1023 set to 1 leave cfg_out unaffected.
//   -> A5 as payload byte 3 is loaded as data.

Source files
------------

// File: rtl/fpga_config_loader_pkg.sv
// rtl/fpga_config_loader_pkg.sv - shared constants for the fabric configuration loader
package fpga_config_loader_pkg;

    localparam int CFG_BITS = 1020;
    localparam int NBYTES   = (CFG_BITS + 7) / 8;
    localparam int CNT_W    = $clog2(NBYTES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CHK    = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    // Slice offsets into cfg_out, shared with the fabric top
    localparam int BRB_LSB      = 0;
    localparam int BRB_BITS     = 900;
    localparam int IO_BITS      = 30;
    localparam int LEFTIO_LSB   = 900;
    localparam int RIGHTIO_LSB  = 930;
    localparam int TOPIO_LSB    = 960;
    localparam int BOTTOMIO_LSB = 990;

endpackage

// File: rtl/fpga_config_loader_if.sv
// rtl/fpga_config_loader_if.sv - byte-wide bitstream handshake into the loader
interface fpga_config_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_config_loader_shadow_reg.sv
// rtl/fpga_config_loader_shadow_reg.sv - byte-addressed shadow of the configuration vector
module fpga_config_loader_shadow_reg
    import fpga_config_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [CNT_W-1:0]    addr,
    input  logic [7:0]          wdata,
    output logic [CFG_BITS-1:0] q
);

    // Per-bit write so padding bits of the last byte are simply never stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int i = 0; i < CFG_BITS; i++) begin
                if (addr == CNT_W'(i / 8)) begin
                    q[i] <= wdata[i % 8];
                end
            end
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - checksummed frame loader with atomic commit to the fabric config vector
module fpga_config_loader
    import fpga_config_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fpga_config_loader_if.slave  bs,
    output logic [CFG_BITS-1:0]  cfg_out,
    output logic                 cfg_valid,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy
);

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [7:0]          xsum;
    logic [CFG_BITS-1:0] shadow;
    logic                xfer;
    logic                shadow_we;

    assign bs.in_ready = rst_n && (state == ST_IDLE || state == ST_LOAD || state == ST_CHK);
    assign xfer        = bs.in_valid && bs.in_ready;
    assign shadow_we   = xfer && (state == ST_LOAD);
    assign busy        = (state == ST_LOAD) || (state == ST_CHK);

    fpga_config_loader_shadow_reg u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (shadow_we),
        .addr  (cnt),
        .wdata (bs.in_data),
        .q     (shadow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            xsum      <= '0;
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer && bs.in_data == SYNC_BYTE) begin
                        state   <= ST_LOAD;
                        cnt     <= '0;
                        xsum    <= '0;
                        cfg_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        xsum <= xsum ^ bs.in_data;
                        // cnt parks on the last index instead of running past it
                        if (cnt == CNT_W'(NBYTES - 1)) begin
                            state <= ST_CHK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        state <= (bs.in_data == xsum) ? ST_COMMIT : ST_ERR;
                    end
                end
                ST_COMMIT: begin
                    cfg_out   <= shadow;
                    cfg_valid <= 1'b1;
                    cfg_done  <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    cfg_err <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - scoreboard bench for the configuration loader
module tb_fpga_config_loader;
    import fpga_config_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpga_config_loader_if bs();
    logic [CFG_BITS-1:0] cfg_out;
    logic cfg_valid, cfg_done, cfg_err, busy;

    fpga_config_loader u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bs        (bs),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    typedef struct {
        bit                  is_err;
        logic [CFG_BITS-1:0] cfg;
        time                 t;
    } exp_t;

    exp_t                sb[$];
    int                  checks = 0;
    int                  errors = 0;
    logic [7:0]          pl [NBYTES];
    logic [CFG_BITS-1:0] committed = '0;
    time                 last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_cfg(input string name, input logic [CFG_BITS-1:0] act, input logic [CFG_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual_low=%h required_low=%h diff_bits=%0d",
                     name, act[63:0], exp[63:0], $countones(act ^ exp));
        end
    endtask

    function automatic logic [CFG_BITS-1:0] cfg_of_pl();
        logic [CFG_BITS-1:0] r;
        for (int i = 0; i < CFG_BITS; i++) r[i] = pl[i / 8][i % 8];
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        @(negedge clk);
        if (stall && $urandom_range(0, 9) < 3) begin
            bs.in_valid = 1'b0;
            @(negedge clk);
        end
        bs.in_data  = b;
        bs.in_valid = 1'b1;
        n = 0;
        while (!bs.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bs.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        last_acc = $time;
        #1 bs.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] chkb, input bit stall, input bit good);
        exp_t e;
        send_byte(SYNC_BYTE, stall);
        for (int i = 0; i < NBYTES; i++) send_byte(pl[i], stall);
        send_byte(chkb, stall);
        if (good) committed = cfg_of_pl();
        e.is_err = !good;
        e.cfg    = committed;
        e.t      = last_acc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pl();
        for (int i = 0; i < NBYTES; i++) pl[i] = 8'h00;
    endtask

    // Monitor: every commit or new error is popped against the scoreboard
    logic                prev_done = 1'b0;
    logic                prev_err  = 1'b0;
    logic [CFG_BITS-1:0] prev_cfg  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_cfg  = cfg_out;
            prev_done = 1'b0;
            prev_err  = cfg_err;
        end else begin
            if (cfg_done && prev_done) chk("done_width", 2, 1);
            if (cfg_out !== prev_cfg) chk("cfg_change_only_at_commit", cfg_done, 1);
            if (cfg_done || (cfg_err && !prev_err)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {cfg_done, cfg_err}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", {cfg_done, cfg_err}, e.is_err ? 32'd1 : 32'd2);
                    chk("event_latency", 32'($time - e.t), 15);
                    chk_cfg("event_cfg", cfg_out, e.cfg);
                    chk("event_valid", cfg_valid, 1);
                end
            end
            prev_cfg  = cfg_out;
            prev_done = cfg_done;
            prev_err  = cfg_err;
        end
    end

    initial begin
        bs.in_data  = 8'h00;
        bs.in_valid = 1'b0;
        clear_pl();

        // Outputs while held in reset
        #12;
        chk("rst_ready", bs.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk_cfg("rst_cfg", cfg_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame: only bit 5 set
        pl[0] = 8'h20;
        send_frame(8'h20, 1'b0, 1'b1);
        wait_drain();
        chk("good_bit5", cfg_out[5], 1);
        chk("good_popcount", $countones(cfg_out), 1);

        // Bad checksum keeps the previous configuration
        pl[0] = 8'h01;
        send_frame(8'h00, 1'b0, 1'b0);
        wait_drain();
        chk("bad_err", cfg_err, 1);
        chk("bad_valid", cfg_valid, 1);
        chk("bad_bit5", cfg_out[5], 1);
        chk("bad_bit0", cfg_out[0], 0);

        // Preamble garbage before a good frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk("garbage_idle_busy", busy, 0);
        pl[0] = 8'h20;
        send_frame(8'h20, 1'b0, 1'b1);
        wait_drain();
        chk("garbage_err_cleared", cfg_err, 0);

        // Reset in the middle of a load
        send_byte(SYNC_BYTE, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(pl[i], 1'b0);
        chk("midload_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_cfg("midload_rst_cfg", cfg_out, '0);
        chk("midload_rst_valid", cfg_valid, 0);
        chk("midload_rst_busy", busy, 0);
        chk("midload_rst_ready", bs.in_ready, 0);
        committed = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h20, 1'b0, 1'b1);
        wait_drain();
        chk("after_rst_bit5", cfg_out[5], 1);

        // A5 inside payload, padding bits set in the last byte; then with stalls
        clear_pl();
        pl[0]   = 8'h20;
        pl[3]   = 8'hA5;
        pl[127] = 8'hF3;
        send_frame(8'h76, 1'b0, 1'b1);
        wait_drain();
        chk("pad_popcount", $countones(cfg_out), 7);
        chk("pad_bits_1017_1016", {cfg_out[1017], cfg_out[1016]}, 2'b11);
        chk("sync_as_data", cfg_out[31:24], 8'hA5);
        send_frame(8'h76, 1'b1, 1'b1);
        wait_drain();
        chk("stall_popcount", $countones(cfg_out), 7);
        chk("stall_byte3", cfg_out[31:24], 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
